l1_port_arbiter: RTL and testbench

L1_PORT_ARBITER -- requirements
Module: l1_port_arbiter

---
 rtl/l1_port_arbiter.sv | 121 ++++++++++++
 tb/tb_l1_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : l1_port_arbiter
//  Purpose  : Arbitrates an instruction-fetch port and a data load/store port
//             onto one single-ported L1 memory. The data port wins by default.
//             A saturating starvation counter forces the instruction port to
//             win once it has been denied MAX_WAIT consecutive cycles.
//             Read data is registered, so responses arrive one cycle after
//             acceptance.
//  Ports    : clk, reset (async, active-high)
//             i_req/i_addr -> i_stall, i_rsp_valid, i_rdata   (fetch port)
//             d_req/d_we/d_addr/d_mask/d_wdata
//                          -> d_stall, d_rsp_valid, d_rdata   (data port)
//             m_read_en/m_read_addr, m_write_en/m_write_addr/m_write_mask/
//             m_write_data -> memory; m_read_data, m_stall <- memory
//  Revision : 1.0  initial release
// ============================================================================
module l1_port_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_stall,
  output logic        i_rsp_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_wdata,
  output logic        d_stall,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        m_read_en,
  output logic [31:0] m_read_addr,
  output logic        m_write_en,
  output logic [31:0] m_write_addr,
  output logic [3:0]  m_write_mask,
  output logic [31:0] m_write_data,
  input  logic [31:0] m_read_data,
  input  logic        m_stall
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       grant_i;
  logic       grant_d;
  logic       i_acc;
  logic       d_acc;

  // The instruction port only beats a pending data request once starved.
  assign grant_i = i_req && (!d_req || (wait_cnt >= WAIT_LIMIT));
  assign grant_d = d_req && !grant_i;

  // A memory stall keeps the grant but blocks completion of either port.
  assign i_acc = grant_i && !m_stall;
  assign d_acc = grant_d && !m_stall;

  assign i_stall = i_req && !i_acc;
  assign d_stall = d_req && !d_acc;

  always_comb begin
    m_read_en    = 1'b0;
    m_read_addr  = 32'h0;
    m_write_en   = 1'b0;
    m_write_addr = 32'h0;
    m_write_mask = 4'h0;
    m_write_data = 32'h0;
    if (grant_i) begin
      m_read_en   = 1'b1;
      m_read_addr = i_addr;
    end else if (grant_d) begin
      if (d_we) begin
        // Write strobes are suppressed under stall so nothing commits
        // before the request is actually accepted.
        m_write_en   = !m_stall;
        m_write_addr = d_addr;
        m_write_mask = m_stall ? 4'h0 : d_mask;
        m_write_data = d_wdata;
      end else begin
        m_read_en   = 1'b1;
        m_read_addr = d_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 4'h0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rdata     <= 32'h0;
      d_rdata     <= 32'h0;
    end else begin
      // Counts consecutive denied fetch cycles, including stalled ones.
      if (i_req && !i_acc) begin
        if (wait_cnt != 4'hF) begin
          wait_cnt <= wait_cnt + 4'h1;
        end
      end else begin
        wait_cnt <= 4'h0;
      end

      i_rsp_valid <= i_acc;
      d_rsp_valid <= d_acc;

      if (i_acc) begin
        i_rdata <= m_read_data;
      end
      // Write acknowledgements pulse d_rsp_valid but leave d_rdata alone.
      if (d_acc && !d_we) begin
        d_rdata <= m_read_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l1_port_arbiter
//  Purpose  : Self-checking bench for l1_port_arbiter. A table of per-cycle
//             stimulus with expected combinational outputs is applied in
//             order. Expected responses are queued when a request is expected
//             to be accepted, and compared one cycle later. Hand-written
//             sequences cover reset and starvation-counter clearing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l1_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_stall;
  logic        i_rsp_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_mask;
  logic [31:0] d_wdata;
  logic        d_stall;
  logic        d_rsp_valid;
  logic [31:0] d_rdata;
  logic        m_read_en;
  logic [31:0] m_read_addr;
  logic        m_write_en;
  logic [31:0] m_write_addr;
  logic [3:0]  m_write_mask;
  logic [31:0] m_write_data;
  logic [31:0] m_read_data;
  logic        m_stall;

  always #5 clk = ~clk;

  l1_port_arbiter #(.MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_stall(i_stall),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask),
    .d_wdata(d_wdata), .d_stall(d_stall), .d_rsp_valid(d_rsp_valid),
    .d_rdata(d_rdata),
    .m_read_en(m_read_en), .m_read_addr(m_read_addr),
    .m_write_en(m_write_en), .m_write_addr(m_write_addr),
    .m_write_mask(m_write_mask), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_stall(m_stall)
  );

  // Memory attached to the DUT, and an independent reference copy that is
  // updated from the expected acceptances in the table.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  assign m_read_data = mem[m_read_addr[7:2]];

  always @(posedge clk) begin
    if (m_write_en && !m_stall) begin
      for (int b = 0; b < 4; b++) begin
        if (m_write_mask[b]) mem[m_write_addr[7:2]][b*8 +: 8] <= m_write_data[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [3:0]  dm;
    logic [31:0] dwd;
    logic        ms;
    logic        eis;
    logic        eds;
    logic        ere;
    logic        ewe;
    logic [31:0] era;
    logic [3:0]  ewm;
  } vec_t;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        dv;
    logic [31:0] dd;
  } rsp_t;

  rsp_t        sb[$];
  vec_t        tbl[16];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] last_i  = 32'h0;
  logic [31:0] last_d  = 32'h0;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
    input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dwd,
    input logic ms, input logic eis, input logic eds, input logic ere,
    input logic ewe, input logic [31:0] era, input logic [3:0] ewm);
    vec_t v;
    v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dwe = dwe; v.da = da;
    v.dm = dm;  v.dwd = dwd; v.ms = ms;
    v.eis = eis; v.eds = eds; v.ere = ere; v.ewe = ewe; v.era = era; v.ewm = ewm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    i_req = v.ir;  i_addr = v.ia;
    d_req = v.dr;  d_we = v.dwe; d_addr = v.da; d_mask = v.dm; d_wdata = v.dwd;
    m_stall = v.ms;
  endtask

  // One table cycle: drive, check combinational outputs, queue the expected
  // response, clock, then pop and compare the response.
  task automatic run_vec(input int idx, input vec_t v);
    rsp_t e;
    rsp_t got;
    drive(v);
    #1;
    check($sformatf("v%0d i_stall", idx), {31'h0, i_stall}, {31'h0, v.eis});
    check($sformatf("v%0d d_stall", idx), {31'h0, d_stall}, {31'h0, v.eds});
    check($sformatf("v%0d m_read_en", idx), {31'h0, m_read_en}, {31'h0, v.ere});
    check($sformatf("v%0d m_write_en", idx), {31'h0, m_write_en}, {31'h0, v.ewe});
    check($sformatf("v%0d m_read_addr", idx), m_read_addr, v.era);
    check($sformatf("v%0d m_write_mask", idx), {28'h0, m_write_mask}, {28'h0, v.ewm});
    e.iv = v.ir && !v.eis;
    e.id = e.iv ? ref_mem[v.ia[7:2]] : last_i;
    e.dv = v.dr && !v.eds;
    e.dd = (e.dv && !v.dwe) ? ref_mem[v.da[7:2]] : last_d;
    if (e.dv && v.dwe) begin
      for (int b = 0; b < 4; b++) begin
        if (v.dm[b]) ref_mem[v.da[7:2]][b*8 +: 8] = v.dwd[b*8 +: 8];
      end
    end
    last_i = e.id;
    last_d = e.dd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check($sformatf("v%0d i_rsp_valid", idx), {31'h0, i_rsp_valid}, {31'h0, got.iv});
    check($sformatf("v%0d i_rdata", idx), i_rdata, got.id);
    check($sformatf("v%0d d_rsp_valid", idx), {31'h0, d_rsp_valid}, {31'h0, got.dv});
    check($sformatf("v%0d d_rdata", idx), d_rdata, got.dd);
  endtask

  initial begin
    vec_t conf_d;
    vec_t conf_i;
    vec_t idle;
    for (int k = 0; k < 64; k++) begin
      mem[k]     = 32'h1000_0000 + k;
      ref_mem[k] = 32'h1000_0000 + k;
    end
    mem[4]     = 32'h0000_0013;
    ref_mem[4] = 32'h0000_0013;

    //          ir  ia     dr  we  da     dm    dwd           ms  eis eds ere ewe era    ewm
    idle   = mk(0, 32'h0,  0, 0, 32'h0,  4'h0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  4'h0);
    conf_d = mk(1, 32'h14, 1, 0, 32'h20, 4'h0, 32'h0,        0, 1, 0, 1, 0, 32'h20, 4'h0);
    conf_i = mk(1, 32'h14, 1, 0, 32'h20, 4'h0, 32'h0,        0, 0, 1, 1, 0, 32'h14, 4'h0);
    tbl[0]  = idle;
    tbl[1]  = mk(1, 32'h10, 0, 0, 32'h0,  4'h0, 32'h0,        0, 0, 0, 1, 0, 32'h10, 4'h0);
    tbl[2]  = idle;
    tbl[3]  = conf_d;
    tbl[4]  = conf_d;
    tbl[5]  = conf_d;
    tbl[6]  = conf_i;
    tbl[7]  = conf_d;
    tbl[8]  = mk(0, 32'h0,  1, 1, 32'h40, 4'h3, 32'hAABBCCDD, 0, 0, 0, 0, 1, 32'h0,  4'h3);
    tbl[9]  = mk(0, 32'h0,  1, 0, 32'h40, 4'h0, 32'h0,        0, 0, 0, 1, 0, 32'h40, 4'h0);
    tbl[10] = mk(0, 32'h0,  1, 1, 32'h44, 4'hF, 32'h12345678, 1, 0, 1, 0, 0, 32'h0,  4'h0);
    tbl[11] = mk(0, 32'h0,  1, 1, 32'h44, 4'hF, 32'h12345678, 1, 0, 1, 0, 0, 32'h0,  4'h0);
    tbl[12] = mk(0, 32'h0,  1, 1, 32'h44, 4'hF, 32'h12345678, 0, 0, 0, 0, 1, 32'h0,  4'hF);
    tbl[13] = mk(1, 32'h10, 0, 0, 32'h0,  4'h0, 32'h0,        1, 1, 0, 1, 0, 32'h10, 4'h0);
    tbl[14] = mk(1, 32'h44, 1, 0, 32'h44, 4'h0, 32'h0,        0, 1, 0, 1, 0, 32'h44, 4'h0);
    tbl[15] = idle;

    // Reset state, checked while reset is held.
    reset = 1'b1;
    drive(idle);
    #2;
    check("reset i_rsp_valid", {31'h0, i_rsp_valid}, 32'h0);
    check("reset d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    check("reset i_rdata", i_rdata, 32'h0);
    check("reset d_rdata", d_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 16; k++) run_vec(k, tbl[k]);
    if (i_rdata !== 32'h0) last_i = last_i;

    // Reset mid-operation: starvation count built up, response pending.
    run_vec(100, conf_d);
    run_vec(101, conf_d);
    drive(conf_d);
    #1;
    reset = 1'b1;
    #1;
    check("async rst i_rdata", i_rdata, 32'h0);
    check("async rst d_rdata", d_rdata, 32'h0);
    check("async rst d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    check("rst comb i_stall", {31'h0, i_stall}, 32'h1);
    @(posedge clk);
    #1;
    check("rst edge i_rsp_valid", {31'h0, i_rsp_valid}, 32'h0);
    check("rst edge d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    check("rst edge d_rdata", d_rdata, 32'h0);
    reset  = 1'b0;
    last_i = 32'h0;
    last_d = 32'h0;

    // A cleared starvation count needs three fresh denials before fetch wins.
    run_vec(102, conf_d);
    run_vec(103, conf_d);
    run_vec(104, conf_d);
    run_vec(105, conf_i);
    run_vec(106, idle);
    run_vec(107, idle);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
